dcr_master: RTL and testbench
=============================

# dcr_master

DCR bus initiator that turns a simple valid/ready command stream into single DCR read and write transfers. It is the master end of the DCR slave interface that `host_if` and the other SATA register blocks expose. It sits between the embedded controller or test sequencer and the DCR bus. Each command produces exactly one response: read data on success, or an error flag on an unacknowledged transfer.

## Interface
Parameters:
- C_TIMEOUT, 255, number of strobe cycles without `Sl_dcrAck` before a transfer is abandoned (range 1..65535).
- C_TIMEOUT_W, 16, width of the timeout counter; must satisfy C_TIMEOUT < 2^C_TIMEOUT_W.

Ports:
- sys_clk  in  1  block clock; DCR clock is the same domain.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = DCR write, 0 = DCR read.
- cmd_addr  in  10  DCR address; cmd_addr[9] drives DCR_ABus[0].
- cmd_wdata  in  32  write data; bit 31 drives DCR_Sl_DBus[0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  transfer timed out; valid with rsp_valid.
- busy  out  1  state != IDLE.
- DCR_Read  out  1  read strobe.
- DCR_Write  out  1  write strobe.
- DCR_ABus  out  [0:9]  address.
- DCR_Sl_DBus  out  [0:31]  write data.
- Sl_dcrDBus  in  [0:31]  slave read data.
- Sl_dcrAck  in  1  slave acknowledge.

## Operation
- Three states: IDLE, XFER, RELEASE. Reset enters IDLE.
- Reset values: DCR_Read=0, DCR_Write=0, DCR_ABus=0, DCR_Sl_DBus=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, cmd_ready=0.
- cmd_ready = (state==IDLE) & ~sys_rst. This is the only combinational output.
- IDLE: on cmd_valid&cmd_ready, register the address, data and direction into the DCR outputs; set DCR_Write=cmd_write and DCR_Read=~cmd_write; clear the timeout counter; go to XFER.
- XFER: strobe, address and data are held stable. When Sl_dcrAck=1:
  - drop the strobe;
  - capture Sl_dcrDBus into rsp_rdata (reads only; 0 for writes);
  - pulse rsp_valid with rsp_err=0;
  - go to RELEASE.
  - Otherwise the counter increments.
- Timeout: when the counter reaches C_TIMEOUT in XFER and Sl_dcrAck=0:
  - drop the strobe;
  - pulse rsp_valid with rsp_err=1 and rsp_rdata=0;
  - go to RELEASE.
  - If Sl_dcrAck=1 in the same cycle the counter reaches C_TIMEOUT, the ack wins.
- RELEASE: wait for Sl_dcrAck=0, then go to IDLE. This guarantees the strobe is never reasserted while the previous ack is high.
- DCR_Read and DCR_Write are never high together.
- sys_rst in any state:
  - all outputs return to reset values at the next edge;
  - no rsp_valid is generated for the aborted transfer;
  - the state goes to IDLE.
- The command interface is unbuffered: one transfer is outstanding at most.

## Timing
- Cycle 0: command accepted.
- Cycle 1: strobe high.
- A slave with registered ack, such as host_if, shows Sl_dcrAck=1 in cycle 2.
- Cycle 3: rsp_valid=1 with data, strobe low.
- The slave drops ack in cycle 4; RELEASE sees it low.
- Cycle 5: cmd_ready=1. Minimum command-to-command spacing is 5 cycles.
- rsp_valid is high exactly one cycle per accepted command. rsp_rdata and rsp_err hold until the next response.
- Timeout response: rsp_valid arrives C_TIMEOUT+2 cycles after acceptance (counter counts XFER cycles 0..C_TIMEOUT).
- If ack stays high forever, the block remains in RELEASE with busy=1. This is not an error.

## Configuration
- DCR_MASTER_TIMEOUT_EN defined:
  - timeout counter and rsp_err path are compiled in, as described above.
- Not defined:
  - no counter;
  - XFER waits indefinitely for Sl_dcrAck;
  - rsp_err is tied to 0;
  - C_TIMEOUT and C_TIMEOUT_W are ignored.

## Test plan
- Write cmd_addr=0x002, cmd_wdata=0x00000001, with the slave acking one cycle after the strobe:
  - DCR_Write is high for 2 cycles;
  - DCR_ABus=0x002 and DCR_Sl_DBus=0x00000001 are stable throughout;
  - rsp_valid arrives in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read cmd_addr=0x010, with the slave returning 0xA5A5_1234 with its ack:
  - rsp_rdata=0xA5A51234, rsp_err=0;
  - DCR_Write stays 0.
- Timeout enabled, C_TIMEOUT=4, slave never acks:
  - strobe drops after 5 XFER cycles;
  - rsp_valid=1 with rsp_err=1 and rsp_rdata=0;
  - cmd_ready returns the cycle after RELEASE.
- Back-to-back commands with cmd_valid held high:
  - acceptances are exactly 5 cycles apart;
  - strobes never overlap an asserted Sl_dcrAck.
- Slave holds ack for 3 extra cycles after the strobe drops:
  - block stays in RELEASE with cmd_ready=0 until ack falls;
  - cmd_ready goes high the next cycle.
- Assert sys_rst for 1 cycle during XFER:
  - strobes are 0 at the next edge;
  - no rsp_valid is generated;
  - a new command is accepted in the cycle after reset deasserts.

Source files
------------

// File: rtl/dcr_master.sv
// dcr_master: single-outstanding DCR bus initiator fed by a valid/ready command stream.
// Optional timeout/error path is compiled in when DCR_MASTER_TIMEOUT_EN is defined.

module dcr_master #(
    parameter int C_TIMEOUT   = 255,
    parameter int C_TIMEOUT_W = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,

    output logic        DCR_Read,
    output logic        DCR_Write,
    output logic [0:9]  DCR_ABus,
    output logic [0:31] DCR_Sl_DBus,
    input  logic [0:31] Sl_dcrDBus,
    input  logic        Sl_dcrAck
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_XFER    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [9:0]  abus_q, abus_d;
    logic [31:0] dbus_q, dbus_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        busy_q, busy_d;
    logic        cmd_accept;

`ifdef DCR_MASTER_TIMEOUT_EN
    localparam logic [C_TIMEOUT_W-1:0] TIMEOUT_LAST = C_TIMEOUT_W'(C_TIMEOUT);

    logic [C_TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   timeout_hit;

    // Counter value equals the number of completed XFER cycles without an ack.
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);
`else
    logic [C_TIMEOUT_W-1:0] unused_timeout_cfg;

    assign unused_timeout_cfg = C_TIMEOUT_W'(C_TIMEOUT);
`endif

    assign cmd_ready  = (state_q == ST_IDLE) & ~sys_rst;
    assign cmd_accept = cmd_valid & cmd_ready;

    // NOTE: every signal written here gets its hold/default value first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        abus_d      = abus_q;
        dbus_d      = dbus_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef DCR_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    abus_d  = cmd_addr;
                    dbus_d  = cmd_wdata;
                    wr_d    = cmd_write;
                    rd_d    = ~cmd_write;
                    state_d = ST_XFER;
`ifdef DCR_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_XFER: begin
                // An ack in the same cycle as the timeout limit takes priority.
                if (Sl_dcrAck) begin
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rd_q ? Sl_dcrDBus : '0;
                    state_d     = ST_RELEASE;
`ifdef DCR_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
`ifdef DCR_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + C_TIMEOUT_W'(1);
                end
`endif
            end

            ST_RELEASE: begin
                // Hold off the next strobe until the slave has released its ack.
                if (!Sl_dcrAck) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            abus_q      <= '0;
            dbus_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            abus_q      <= abus_d;
            dbus_q      <= dbus_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DCR_MASTER_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // cmd_addr[9] / cmd_wdata[31] land on DCR bit 0 through the MSB-first port ranges.
    assign DCR_Read    = rd_q;
    assign DCR_Write   = wr_q;
    assign DCR_ABus    = abus_q;
    assign DCR_Sl_DBus = dbus_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dcr_master.sv
// tb_dcr_master: directed stimulus with a response scoreboard for dcr_master.
// Timeout scenario runs only when DCR_MASTER_TIMEOUT_EN is defined.

module tb_dcr_master;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        DCR_Read;
    logic        DCR_Write;
    logic [0:9]  DCR_ABus;
    logic [0:31] DCR_Sl_DBus;
    logic [0:31] Sl_dcrDBus;
    logic        Sl_dcrAck;

    logic [31:0] slave_rdata;
    int          slave_mode;   // 0 registered ack, 1 never ack, 2 ack held 3 extra cycles

    rsp_t        exp_q[$];
    int          n_checks;
    int          n_fail;
    int          n_push;
    int          n_rsp;

    dcr_master #(
        .C_TIMEOUT   (4),
        .C_TIMEOUT_W (16)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .DCR_Read    (DCR_Read),
        .DCR_Write   (DCR_Write),
        .DCR_ABus    (DCR_ABus),
        .DCR_Sl_DBus (DCR_Sl_DBus),
        .Sl_dcrDBus  (Sl_dcrDBus),
        .Sl_dcrAck   (Sl_dcrAck)
    );

    assign Sl_dcrDBus = slave_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        check1("cmd_ready_at_issue", cmd_ready, 1'b1);
        if (push) begin
            e.err   = exp_err;
            e.rdata = exp_rdata;
            exp_q.push_back(e);
            n_push++;
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check1(name, cmd_ready, 1'b1);
    endtask

    // Registered slave: ack in cycle n is a function of the strobe seen in cycle n-1.
    initial begin
        logic s;
        logic nxt;
        int   hold;
        Sl_dcrAck = 1'b0;
        hold      = 0;
        forever begin
            @(negedge clk);
            s = DCR_Read | DCR_Write;
            nxt = 1'b0;
            case (slave_mode)
                0: nxt = s;
                1: nxt = 1'b0;
                default: begin
                    if (s) begin
                        nxt  = 1'b1;
                        hold = 3;
                    end else if (hold > 0) begin
                        nxt  = 1'b1;
                        hold = hold - 1;
                    end
                end
            endcase
            @(posedge clk);
            #2;
            Sl_dcrAck = nxt;
        end
    end

    // Monitor: scoreboard compare on every response, protocol checks on every strobe rise.
    initial begin
        rsp_t e;
        logic prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    check1("unexpected_rsp_valid", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check32("rsp_rdata", rsp_rdata, e.rdata);
                    check1("rsp_err", rsp_err, e.err);
                end
            end
            if ((DCR_Read | DCR_Write) && !prev_strobe) begin
                check1("strobe_rise_ack_low", Sl_dcrAck, 1'b0);
                check1("strobes_exclusive", DCR_Read & DCR_Write, 1'b0);
            end
            prev_strobe = DCR_Read | DCR_Write;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    localparam int NB = 4;

    initial begin
        logic        b_wr   [NB];
        logic [9:0]  b_addr [NB];
        logic [31:0] b_wd   [NB];
        logic [31:0] b_rd   [NB];
        int          acc    [NB];
        int          k;

        n_checks = 0; n_fail = 0; n_push = 0; n_rsp = 0;
        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; slave_rdata = 32'hDEADBEEF; slave_mode = 0;

        // Reset state
        step(); step();
        check1("rst_read", DCR_Read, 1'b0);
        check1("rst_write", DCR_Write, 1'b0);
        check32("rst_abus", 32'(DCR_ABus), 32'h0);
        check32("rst_dbus", DCR_Sl_DBus, 32'h0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_rsp_rdata", rsp_rdata, 32'h0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_cmd_ready", cmd_ready, 1'b0);
        sys_rst = 1'b0;
        #1;

        // Write 0x002 <- 1; bus data present must not leak into rsp_rdata
        issue(1'b1, 10'h002, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
        check1("wr_c1_write", DCR_Write, 1'b1);
        check1("wr_c1_read", DCR_Read, 1'b0);
        check32("wr_c1_abus", 32'(DCR_ABus), 32'h002);
        check32("wr_c1_dbus", DCR_Sl_DBus, 32'h0000_0001);
        step();
        check1("wr_c2_write", DCR_Write, 1'b1);
        check32("wr_c2_abus", 32'(DCR_ABus), 32'h002);
        check32("wr_c2_dbus", DCR_Sl_DBus, 32'h0000_0001);
        check1("wr_c2_rsp_valid", rsp_valid, 1'b0);
        step();
        check1("wr_c3_write", DCR_Write, 1'b0);
        check1("wr_c3_rsp_valid", rsp_valid, 1'b1);
        step();
        check1("wr_c4_cmd_ready", cmd_ready, 1'b0);
        check1("wr_c4_busy", busy, 1'b1);
        check1("wr_c4_rsp_valid", rsp_valid, 1'b0);
        step();
        check1("wr_c5_cmd_ready", cmd_ready, 1'b1);
        check1("wr_c5_busy", busy, 1'b0);

        // Read 0x010 returning 0xA5A51234
        slave_rdata = 32'hA5A5_1234;
        issue(1'b0, 10'h010, 32'h0, 32'hA5A5_1234, 1'b0, 1'b1);
        check1("rd_c1_read", DCR_Read, 1'b1);
        check1("rd_c1_write", DCR_Write, 1'b0);
        check32("rd_c1_abus", 32'(DCR_ABus), 32'h010);
        step();
        check1("rd_c2_write", DCR_Write, 1'b0);
        step();
        check1("rd_c3_rsp_valid", rsp_valid, 1'b1);
        check1("rd_c3_read", DCR_Read, 1'b0);
        check1("rd_c3_write", DCR_Write, 1'b0);
        step();
        slave_rdata = 32'h0;
        step();
        check32("rd_rdata_hold", rsp_rdata, 32'hA5A5_1234);
        check1("rd_c5_cmd_ready", cmd_ready, 1'b1);

        // Back-to-back with cmd_valid held high
        b_wr[0] = 1'b1; b_addr[0] = 10'h200; b_wd[0] = 32'h8000_0001; b_rd[0] = 32'h0;
        b_wr[1] = 1'b0; b_addr[1] = 10'h3FF; b_wd[1] = 32'h0;         b_rd[1] = 32'h1357_9BDF;
        b_wr[2] = 1'b0; b_addr[2] = 10'h155; b_wd[2] = 32'h0;         b_rd[2] = 32'h2468_ACE0;
        b_wr[3] = 1'b1; b_addr[3] = 10'h001; b_wd[3] = 32'h0F00_00F0; b_rd[3] = 32'h0;
        k = 0;
        cmd_valid = 1'b1; cmd_write = b_wr[0]; cmd_addr = b_addr[0]; cmd_wdata = b_wd[0];
        for (int c = 0; c < 60 && k < NB; c++) begin
            if (cmd_ready) begin
                rsp_t e;
                slave_rdata = b_wr[k] ? 32'hFFFF_FFFF : b_rd[k];
                e.err = 1'b0;
                e.rdata = b_rd[k];
                exp_q.push_back(e);
                n_push++;
                acc[k] = c;
                k++;
                step();
                check32("b2b_abus", 32'(DCR_ABus), 32'(b_addr[k-1]));
                check32("b2b_dbus", DCR_Sl_DBus, b_wd[k-1]);
                if (k < NB) begin
                    cmd_write = b_wr[k]; cmd_addr = b_addr[k]; cmd_wdata = b_wd[k];
                end else begin
                    cmd_valid = 1'b0;
                end
            end else begin
                step();
            end
        end
        cmd_valid = 1'b0;
        check32("b2b_accept_count", 32'(k), 32'(NB));
        for (int i = 1; i < k; i++) begin
            check32("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd5);
        end
        wait_ready("b2b_drain_ready");

`ifdef DCR_MASTER_TIMEOUT_EN
        // Timeout with C_TIMEOUT=4 and a slave that never acks
        slave_mode = 1;
        slave_rdata = 32'hFFFF_FFFF;
        issue(1'b0, 10'h0AA, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            check1("to_strobe_held", DCR_Read, 1'b1);
            if (c < 5) step();
        end
        step();
        check1("to_c6_read", DCR_Read, 1'b0);
        check1("to_c6_rsp_valid", rsp_valid, 1'b1);
        check1("to_c6_cmd_ready", cmd_ready, 1'b0);
        step();
        check1("to_c7_cmd_ready", cmd_ready, 1'b1);
`endif

        // Slave holds ack three extra cycles after the strobe drops
        slave_mode = 2;
        issue(1'b1, 10'h123, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
        step(); step();
        check1("hold_c3_rsp_valid", rsp_valid, 1'b1);
        for (int c = 4; c <= 7; c++) begin
            step();
            check1("hold_cmd_ready_low", cmd_ready, 1'b0);
        end
        step();
        check1("hold_c8_cmd_ready", cmd_ready, 1'b1);
        slave_mode = 0;

        // One-cycle reset during XFER aborts the read without a response
        issue(1'b0, 10'h077, 32'h0, 32'h0, 1'b0, 1'b0);
        check1("rst_xfer_c1_read", DCR_Read, 1'b1);
        sys_rst = 1'b1;
        step();
        check1("rst_xfer_read", DCR_Read, 1'b0);
        check1("rst_xfer_write", DCR_Write, 1'b0);
        check1("rst_xfer_busy", busy, 1'b0);
        check1("rst_xfer_rsp_valid", rsp_valid, 1'b0);
        check32("rst_xfer_abus", 32'(DCR_ABus), 32'h0);
        check1("rst_xfer_cmd_ready", cmd_ready, 1'b0);
        sys_rst = 1'b0;
        #1;
        slave_rdata = 32'h0F0F_F0F0;
        issue(1'b0, 10'h3C5, 32'h0, 32'h0F0F_F0F0, 1'b0, 1'b1);
        check1("post_rst_c1_rsp_valid", rsp_valid, 1'b0);
        check1("post_rst_c1_read", DCR_Read, 1'b1);
        step();
        check1("post_rst_c2_rsp_valid", rsp_valid, 1'b0);
        step();
        check1("post_rst_c3_rsp_valid", rsp_valid, 1'b1);
        wait_ready("post_rst_ready");

        repeat (3) step();
        check32("sb_empty", 32'(exp_q.size()), 32'h0);
        check32("rsp_count", 32'(n_rsp), 32'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
